div_issue_queue: RTL
====================

DIV_ISSUE_QUEUE -- requirements
Module: div_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO depth; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 8'd100, maximum cycles allowed in WAIT_DONE.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 async_rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream operand pair present.
REQ-006 in_ready  output  1  FIFO not full; a push occurs when in_valid and in_ready are both high.
REQ-007 in_dividend, in_divisor  input  32 each  signed operands.
REQ-008 div_valid  output  1  one-cycle start pulse to divider32.
REQ-009 div_dividend, div_divisor  output  32 each  operands to divider32, held stable from ISSUE until capture.
REQ-010 div_Q, div_R  input  32 each  divider32 results.
REQ-011 div_ready  input  1  divider32 idle/result-valid level; low while busy.
REQ-012 out_valid  output  1  result register full.
REQ-013 out_ready  input  1  downstream accept; a pop occurs when out_valid and out_ready are both high.
REQ-014 out_q, out_r  output  32 each  quotient and remainder.
REQ-015 out_dz, out_ovf, out_tmo  output  1 each  flags: divide-by-zero, overflow, timeout.
REQ-016 count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 FIFO: circular buffer with wrap-around pointers; count range 0..DEPTH; in_ready = (count != DEPTH).
REQ-018 FIFO push and pop in the same cycle leave count unchanged; at count == DEPTH, in_valid is ignored.
REQ-019 Controller states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-020 IDLE: if the FIFO is non-empty and div_ready = 1, pop the head into the operand registers.
REQ-021 IDLE special cases: head divisor == 0 goes directly to HOLD with out_q = 32'hFFFFFFFF, out_r = dividend, out_dz = 1.
REQ-022 IDLE special cases: head 32'h80000000 / 32'hFFFFFFFF goes directly to HOLD with out_q = 32'h80000000, out_r = 0, out_ovf = 1.
REQ-023 IDLE: all other operand pairs go to ISSUE.
REQ-024 ISSUE: div_valid = 1 for exactly one cycle, then WAIT_BUSY.
REQ-025 WAIT_BUSY: on div_ready = 0, go to WAIT_DONE; if div_ready stays high for 4 cycles, go to WAIT_DONE anyway.
REQ-026 WAIT_DONE: a cycle counter increments every cycle.
REQ-027 WAIT_DONE: on div_ready = 1, capture div_Q/div_R into out_q/out_r, clear all flags, go to HOLD.
REQ-028 WAIT_DONE: if the counter reaches TIMEOUT first, set out_q = out_r = 0 and out_tmo = 1, then go to HOLD.
REQ-029 HOLD: out_valid = 1; out_q, out_r and flags are stable until a pop.
REQ-030 HOLD pop: go to IDLE; the next pop from the FIFO can occur no earlier than the following cycle.
REQ-031 Ordering: results leave in push order; there is at most one operation in flight.
REQ-032 Latency: bypass case (divide-by-zero or overflow) gives out_valid 2 cycles after the push into an empty FIFO.
REQ-033 Latency: divider case gives out_valid the cycle after div_ready rises.
REQ-034 div_valid is never asserted outside ISSUE.
REQ-035 Pushes are accepted in every state.

Reset
REQ-036 async_rst_n low immediately forces state IDLE, count = 0, both pointers = 0, and clears the WAIT_DONE counter.
REQ-037 async_rst_n low immediately forces div_valid = 0, in_ready = 1, out_valid = 0, out_q = out_r = 0, and all flags = 0.
REQ-038 Reset asserted mid-operation discards all FIFO contents and any in-flight result; no output pulse follows deassertion.
REQ-039 Deassertion is sampled synchronously; the first push is accepted on the first clock edge after deassertion.

Verification
REQ-040 Push 32'h26A5515D / 32'h000E895A with a divider32 model attached -> one div_valid pulse; then out_q = 32'h000002A8, out_r = 32'h00087A4D, flags 0.
REQ-041 Push four pairs back-to-back (32'hD5547562/32'h000435CA, 32'h44B7495A/32'hFFFFD362, 32'hD1D54D1D/32'hFFFE25EA, plus the REQ-040 pair) with out_ready held high -> results in order:
- 32'hFFFFF5DE/32'hFFFD7E36
- 32'hFFFE75BB/32'h000016C4
- 32'h000018ED/32'hFFFE437B
- 32'h000002A8/32'h00087A4D
REQ-042 Push DEPTH+1 pairs while the divider is stalled busy -> in_ready low at count = DEPTH; the extra pair is not accepted.
REQ-043 Push 32'h12345678 / 0 -> no div_valid; out_q = 32'hFFFFFFFF, out_r = 32'h12345678, out_dz = 1.
REQ-043 Push 32'h80000000 / 32'hFFFFFFFF -> no div_valid; out_q = 32'h80000000, out_r = 0, out_ovf = 1.
REQ-044 Hold div_ready low indefinitely -> out_tmo = 1 with out_q = out_r = 0 after TIMEOUT cycles.
REQ-045 Assert async_rst_n low during WAIT_DONE -> all outputs clear asynchronously; count = 0; no stale result appears later.

Source files
------------

// File: rtl/div_issue_queue.sv
// Operand FIFO in front of a multi-cycle signed divider, with in-order result hold,
// divide-by-zero / overflow bypass and a WAIT_DONE timeout.
//
// state       | meaning
// S_IDLE      | waiting for a FIFO entry and an idle divider
// S_ISSUE     | one-cycle start pulse to the divider
// S_WAIT_BUSY | waiting for the divider to drop ready (4 cycles max)
// S_WAIT_DONE | waiting for the divider result, bounded by TIMEOUT
// S_HOLD      | result register full, waiting for downstream accept
module div_issue_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [7:0]  TIMEOUT = 8'd100
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_dividend,
  input  logic [31:0]              in_divisor,
  output logic                     div_valid,
  output logic [31:0]              div_dividend,
  output logic [31:0]              div_divisor,
  input  logic [31:0]              div_Q,
  input  logic [31:0]              div_R,
  input  logic                     div_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_q,
  output logic [31:0]              out_r,
  output logic                     out_dz,
  output logic                     out_ovf,
  output logic                     out_tmo,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   op_a, op_b;
  logic [1:0]    busy_cnt;
  logic [7:0]    wd_cnt;

  logic        push, pop;
  logic [31:0] head_a, head_b;
  logic        head_dz, head_ovf, wd_last;

  assign in_ready     = (count != FULL);
  assign push         = in_valid && in_ready;
  assign head_a       = mem_a[rd_ptr];
  assign head_b       = mem_b[rd_ptr];
  assign head_dz      = (head_b == 32'h0);
  assign head_ovf     = (head_a == 32'h8000_0000) && (head_b == 32'hFFFF_FFFF);
  assign wd_last      = (wd_cnt == TIMEOUT - 8'd1);
  assign div_valid    = (state == S_ISSUE);
  assign out_valid    = (state == S_HOLD);
  assign div_dividend = op_a;
  assign div_divisor  = op_b;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if ((count != '0) && div_ready) begin
          pop       = 1'b1;
          state_nxt = (head_dz || head_ovf) ? S_HOLD : S_ISSUE;
        end
      end
      S_ISSUE:     state_nxt = S_WAIT_BUSY;
      // A divider that never drops ready is still given a chance to answer.
      S_WAIT_BUSY: if (!div_ready || (busy_cnt == 2'd3)) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (div_ready || wd_last) state_nxt = S_HOLD;
      S_HOLD:      if (out_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Storage array carries no reset; occupancy is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_dividend;
      mem_b[wr_ptr] <= in_divisor;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      busy_cnt <= 2'd0;
      wd_cnt   <= 8'd0;
      op_a     <= 32'h0;
      op_b     <= 32'h0;
      out_q    <= 32'h0;
      out_r    <= 32'h0;
      out_dz   <= 1'b0;
      out_ovf  <= 1'b0;
      out_tmo  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;

      busy_cnt <= (state == S_WAIT_BUSY) ? busy_cnt + 2'd1 : 2'd0;
      wd_cnt   <= (state == S_WAIT_DONE) ? wd_cnt + 8'd1 : 8'd0;

      if (pop) begin
        op_a <= head_a;
        op_b <= head_b;
        if (head_dz) begin
          out_q   <= 32'hFFFF_FFFF;
          out_r   <= head_a;
          out_dz  <= 1'b1;
          out_ovf <= 1'b0;
          out_tmo <= 1'b0;
        end else if (head_ovf) begin
          out_q   <= 32'h8000_0000;
          out_r   <= 32'h0;
          out_dz  <= 1'b0;
          out_ovf <= 1'b1;
          out_tmo <= 1'b0;
        end
      end

      if (state == S_WAIT_DONE) begin
        if (div_ready) begin
          out_q   <= div_Q;
          out_r   <= div_R;
          out_dz  <= 1'b0;
          out_ovf <= 1'b0;
          out_tmo <= 1'b0;
        end else if (wd_last) begin
          out_q   <= 32'h0;
          out_r   <= 32'h0;
          out_dz  <= 1'b0;
          out_ovf <= 1'b0;
          out_tmo <= 1'b1;
        end
      end
    end
  end

endmodule
